riscv_muldiv_ctrl: RTL and testbench
====================================

# riscv_muldiv_ctrl

Iterative M-extension sequencer in the pipelined RV32I execute stage. It sits beside the single-cycle ALU and takes the forwarded SrcA and write-data operands for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. While the operation runs, it holds the pipeline through a stall request to the hazard unit. It returns the result to the E-stage result mux for exactly one cycle.

## Interface
- XLEN, 32, operand/result width; must be even, ≥ 8
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  M-ext instruction valid in E (ctrl_muldivE, already gated by flushE)
- i_funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_op_a  in  XLEN  forwarded rs1 (SrcAE)
- i_op_b  in  XLEN  forwarded rs2 (mem write-data path, not immediate)
- i_kill  in  1  abort current op (flush/trap); priority over i_start
- o_busy  out  1  stall request to hazard unit (stallF/stallD/stallE)
- o_done  out  1  result valid this cycle
- o_result  out  XLEN  result; held until next accepted start

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE**
  - Accept when i_start & !i_kill.
  - Latch funct3 and |op_a|, |op_b| (negate negative signed operands).
  - Record result-sign flags and the raw dividend.
  - Load counter = XLEN-1, then go to BUSY.
  - Fast path (DIV/DIVU/REM/REMU only): go straight to DONE with the result loaded.
    - Divisor == 0: quotient = all-ones; remainder = dividend.
    - Signed DIV/REM with op_a = 0x8000…0 and op_b = all-ones: quotient = 0x8000…0; remainder = 0.
- **BUSY**
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract giving quotient and remainder.
  - When counter == 0, apply sign fix and select the result, then go to DONE; otherwise decrement the counter.
- **Sign rules**
  - MUL: low XLEN bits.
  - MULH: signed×signed, high half.
  - MULHSU: signed a × unsigned b, high half.
  - MULHU: unsigned, high half.
  - Product negated if the operand signs differ (MULHSU: only a's sign).
  - DIV quotient negated if the signs differ.
  - REM takes the dividend's sign.
- **DONE**
  - o_done=1, o_busy=0.
  - i_start is ignored here, because the same instruction is still in E.
  - Go to IDLE unconditionally.
- **i_kill**
  - In any state, go to IDLE next cycle.
  - No o_done; o_result is unchanged.
- **o_busy** is combinational: (IDLE & i_start & !i_kill) | BUSY. It is forced 0 while i_rst=1.
- **Reset values**
  - State: IDLE.
  - Counter, accumulators, o_result: 0.
  - o_done: 0.
  - o_busy: 0.
- A reset mid-operation abandons the operation with no o_done.

## Timing
- **Cycle 0:** i_start seen in IDLE; o_busy=1 in the same cycle, so E holds.
- **Cycles 1..XLEN:** BUSY, o_busy=1.
- **Cycle XLEN+1:** DONE, o_done=1, o_result valid; the pipeline advances at the end of this cycle.
  - Stall = XLEN+1 cycles (33 at XLEN=32).
- **Fast path:** cycle 0 with o_busy=1, then DONE at cycle 1 (1 stall cycle).
- **Back-to-back ops:** the next i_start is accepted in the IDLE cycle immediately after DONE.
- **Result hold:** o_result is registered and stable from DONE until the next accepted start, then loaded again at that op's DONE.
- **Kill timing:** i_kill and i_start in the same IDLE cycle → no start, o_busy=0.

## Structure
- Shared constants go into the common config include: funct3 encodings (FUNCT3_MUL … FUNCT3_REMU), the state encoding, and the muldiv opcode/funct7 (0000001) decode constants.
- One sub-module, **riscv_muldiv_step**: the combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator.
- riscv_muldiv_ctrl keeps the FSM, counter, operand/sign registers, fast-path detect and result selection.

## Test plan
- MUL 7 × 0xFFFFFFFD → o_result 0xFFFFFFEB.
  - o_busy high for cycles 0–32; o_done only at cycle 33.
- High-half multiplies with 0xFFFFFFFF × 0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- Divides:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Each completes in 33 stall cycles.
- Fast paths:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - Each has o_done at cycle 1.
- Kill and reset:
  - i_kill asserted at BUSY cycle 10 → IDLE next cycle, no o_done, o_result keeps its prior value.
  - i_rst asserted mid-BUSY → all outputs 0 next cycle.
  - A new MUL 3×4 issued immediately after either → 12.
- Back-to-back DIVU 9/3 then MULHU 2×3:
  - Second start accepted the cycle after the first DONE.
  - Results 3, then 0; no lost or duplicate o_done.

Source files
------------

// File: rtl/riscv_muldiv_ctrl_pkg.sv
// Shared constants and types for the iterative M-extension sequencer:
// funct3 encodings, M-ext decode constants, FSM state and step-mode enums.
package riscv_muldiv_ctrl_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/riscv_muldiv_ctrl_if.sv
// E-stage <-> muldiv sequencer bundle. start is a level held by the stalled
// E stage; busy is the stall request; done qualifies result for one cycle.
interface riscv_muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, kill,
    output busy, done, result
  );
endinterface

// File: rtl/riscv_muldiv_ctrl_step.sv
// One radix-2 iteration: shift-add multiply ({hi, multiplier}) or restoring
// shift-subtract divide ({remainder, quotient}) on a 2*XLEN accumulator.
module riscv_muldiv_step
  import riscv_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  input  step_mode_t        i_mode,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_mul_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_mul_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    // Shifted partial remainder needs one extra bit before the trial subtract.
    w_rem_sh  = i_acc[2*XLEN-1:XLEN-1];
    w_diff    = w_rem_sh - {1'b0, i_operand};
    o_acc     = '0;
    if (i_mode == STEP_MUL) begin
      o_acc = {w_mul_sum, i_acc[XLEN-1:1]};
    end else if (!w_diff[XLEN]) begin
      o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
    end else begin
      o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/riscv_muldiv_ctrl.sv
// Iterative M-extension sequencer: IDLE/BUSY/DONE FSM, operand magnitude and
// sign capture, divide fast paths, and final sign fix / result selection.
module riscv_muldiv_ctrl
  import riscv_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  riscv_muldiv_ctrl_if.slave  bus,
  output muldiv_state_t       o_dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);

  muldiv_state_t     r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_op_b;
  logic [2:0]        r_funct3;
  logic              r_neg;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_fast_result;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;
  step_mode_t        w_mode;

  assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.kill;

  always_comb begin
    w_is_div   = bus.funct3[2];
    w_a_signed = (bus.funct3 == FUNCT3_MULH) || (bus.funct3 == FUNCT3_MULHSU) ||
                 (bus.funct3 == FUNCT3_DIV)  || (bus.funct3 == FUNCT3_REM);
    w_b_signed = (bus.funct3 == FUNCT3_MULH) || (bus.funct3 == FUNCT3_DIV) ||
                 (bus.funct3 == FUNCT3_REM);
    w_a_neg    = w_a_signed && bus.op_a[XLEN-1];
    w_b_neg    = w_b_signed && bus.op_b[XLEN-1];
    w_a_mag    = w_a_neg ? (XLEN'(0) - bus.op_a) : bus.op_a;
    w_b_mag    = w_b_neg ? (XLEN'(0) - bus.op_b) : bus.op_b;
    // Remainder follows the dividend; everything else follows the sign xor.
    w_neg      = (bus.funct3 == FUNCT3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = w_is_div && (bus.op_b == '0);
    w_div_ovf  = w_is_div && !bus.funct3[0] && (bus.op_a == XMIN) && (bus.op_b == '1);
    if (w_div_zero) begin
      w_fast_result = bus.funct3[1] ? bus.op_a : '1;
    end else begin
      w_fast_result = bus.funct3[1] ? '0 : XMIN;
    end
  end

  assign w_mode = r_funct3[2] ? STEP_DIV : STEP_MUL;

  riscv_muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_op_b),
    .i_mode    (w_mode),
    .o_acc     (w_acc_next)
  );

  always_comb begin
    w_prod  = r_neg ? ((2*XLEN)'(0) - w_acc_next) : w_acc_next;
    w_quo   = w_acc_next[XLEN-1:0];
    w_rem   = w_acc_next[2*XLEN-1:XLEN];
    w_final = '0;
    case (r_funct3)
      FUNCT3_MUL:                 w_final = w_prod[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU,
      FUNCT3_MULHU:               w_final = w_prod[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:    w_final = r_neg ? (XLEN'(0) - w_quo) : w_quo;
      default:                    w_final = r_neg ? (XLEN'(0) - w_rem) : w_rem;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_op_b   <= '0;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_funct3 <= bus.funct3;
            r_neg    <= w_neg;
            r_op_b   <= w_b_mag;
            r_acc    <= {{XLEN{1'b0}}, w_a_mag};
            r_cnt    <= CNT_LOAD;
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_fast_result;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_state  <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (bus.kill) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_acc_next;
            if (r_cnt == '0) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = !i_rst && (w_accept || (r_state == ST_BUSY));
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_riscv_muldiv_ctrl.sv
// Self-checking bench for riscv_muldiv_ctrl: directed and random ops against
// an arithmetic reference model, plus kill, reset and back-to-back cases.
module tb_riscv_muldiv_ctrl;
  import riscv_muldiv_ctrl_pkg::*;

  localparam int XLEN = 32;

  logic          clk;
  logic          rst;
  muldiv_state_t dbg_state;

  riscv_muldiv_ctrl_if #(.XLEN(XLEN)) bus ();

  riscv_muldiv_ctrl #(.XLEN(XLEN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total;
  int n_pass;
  int n_done_seen;
  int n_done_exp;
  logic [XLEN-1:0] last_result;
  logic [XLEN-1:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.done === 1'b1) n_done_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // reference model: plain 64-bit arithmetic from the M-extension rules
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 1;
  endfunction

  // driver: starts in the cycle after the call, holds start while stalled,
  // returns in the DONE cycle (start still high, as E has not advanced yet)
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    int cyc;
    int busy_bad;
    bit seen;
    int lat;
    logic [31:0] exp;
    exp = model(f3, a, b);
    lat = model_latency(f3, a, b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.kill = 1'b0;
    #1;
    check({tag, "_busy_c0"}, bus.busy, 1);
    exp_q.push_back(exp);
    n_done_exp++;
    cyc = 0; seen = 0; busy_bad = 0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
      if (bus.done === 1'b1) seen = 1;
      else if (bus.busy !== 1'b1) busy_bad++;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_held"}, busy_bad, 0);
    if (seen) begin
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_busy_at_done"}, bus.busy, 0);
      check({tag, "_result"}, bus.result, exp_q.pop_front());
      last_result = exp;
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
  endtask

  // abort a MUL at BUSY cycle 10 via kill or reset
  task automatic abort_op(input string tag, input bit use_rst);
    logic [31:0] prior;
    prior = last_result;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = FUNCT3_MUL; bus.op_a = $urandom; bus.op_b = $urandom;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #2;
    end
    check({tag, "_busy_c10"}, bus.busy, 1);
    bus.start = 1'b0;
    if (use_rst) begin
      rst = 1'b1;
      #1;
      check({tag, "_busy_forced_low"}, bus.busy, 0);
    end else begin
      bus.kill = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.kill = 1'b0;
    #1;
    check({tag, "_state_idle"}, dbg_state, ST_IDLE);
    check({tag, "_no_done"}, bus.done, 0);
    check({tag, "_busy_low"}, bus.busy, 0);
    check({tag, "_result"}, bus.result, use_rst ? 32'h0 : prior);
    if (use_rst) last_result = '0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0; n_pass = 0; n_done_seen = 0; n_done_exp = 0; last_result = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op_a = 32'd1; bus.op_b = 32'd1;
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    check("reset_state", dbg_state, ST_IDLE);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("mul_7_neg3", FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD);         idle();
    check("mul_7_neg3_const", last_result, 32'hFFFF_FFEB);
    run_op("mulhu_ones", FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  idle();
    check("mulhu_ones_const", last_result, 32'hFFFF_FFFE);
    run_op("mulh_ones", FUNCT3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);    idle();
    check("mulh_ones_const", last_result, 32'h0);
    run_op("mulhsu_ones", FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle();
    check("mulhsu_ones_const", last_result, 32'hFFFF_FFFF);
    run_op("div_m7_2", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2);              idle();
    check("div_m7_2_const", last_result, 32'hFFFF_FFFD);
    run_op("rem_m7_2", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2);              idle();
    check("rem_m7_2_const", last_result, 32'hFFFF_FFFF);
    run_op("remu_100_7", FUNCT3_REMU, 32'd100, 32'd7);                 idle();
    check("remu_100_7_const", last_result, 32'd2);
    run_op("div_5_0", FUNCT3_DIV, 32'd5, 32'd0);                       idle();
    check("div_5_0_const", last_result, 32'hFFFF_FFFF);
    run_op("remu_5_0", FUNCT3_REMU, 32'd5, 32'd0);                     idle();
    check("remu_5_0_const", last_result, 32'd5);
    run_op("div_ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);       idle();
    check("div_ovf_const", last_result, 32'h8000_0000);
    run_op("rem_ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF);       idle();
    check("rem_ovf_const", last_result, 32'h0);
    run_op("divu_100_7", FUNCT3_DIVU, 32'd100, 32'd7);                 idle();
    check("divu_100_7_const", last_result, 32'd14);

    abort_op("kill", 1'b0);
    run_op("mul_after_kill", FUNCT3_MUL, 32'd3, 32'd4);                idle();
    check("mul_after_kill_const", last_result, 32'd12);
    abort_op("rst", 1'b1);
    run_op("mul_after_rst", FUNCT3_MUL, 32'd3, 32'd4);                 idle();
    check("mul_after_rst_const", last_result, 32'd12);

    // back-to-back: second start lands in the IDLE cycle right after DONE
    run_op("b2b_divu", FUNCT3_DIVU, 32'd9, 32'd3);
    check("b2b_divu_const", last_result, 32'd3);
    run_op("b2b_mulhu", FUNCT3_MULHU, 32'd2, 32'd3);                   idle();
    check("b2b_mulhu_const", last_result, 32'd0);

    // kill and start together in IDLE: nothing starts
    @(posedge clk); #1;
    bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = FUNCT3_MUL;
    #1;
    check("kill_start_busy", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    #1;
    check("kill_start_state", dbg_state, ST_IDLE);
    check("kill_start_done", bus.done, 0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int sel;
      f3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      else if (sel == 3) b = {28'hFFFF_FFF, 4'($urandom_range(0, 15))};
      run_op("rand", f3, a, b);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("done_pulse_count", n_done_seen, n_done_exp);
    check("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
